// File: rtl/alu_multiciclo_if.sv
// rtl/alu_multiciclo_if.sv - request/result handshake bundle for the multicycle ALU
interface alu_multiciclo_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       ALUOp;
   logic             entrada_valid;
   logic             entrada_ready;
   logic [WIDTH-1:0] resultado;
   logic             zero;
   logic             eq;
   logic             carry;
   logic             overflow;
   logic             neg;
   logic             saida_valid;
   logic             saida_ready;

   modport master (
      output A, B, ALUOp, entrada_valid, saida_ready,
      input  entrada_ready, resultado, zero, eq, carry, overflow, neg, saida_valid
   );

   modport slave (
      input  A, B, ALUOp, entrada_valid, saida_ready,
      output entrada_ready, resultado, zero, eq, carry, overflow, neg, saida_valid
   );
endinterface

// File: rtl/alu_multiciclo.sv
// rtl/alu_multiciclo.sv - registered ALU with valid/ready handshake and iterative shift-add MUL
module alu_multiciclo #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   alu_multiciclo_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {OCIOSO, MULT, PRONTO} state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   mpl;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcd;
   logic [2*WIDTH-1:0] prod_next;
   logic [CW-1:0]      cnt;
   logic               accept;
   logic [WIDTH:0]     sum_c;
   logic [WIDTH:0]     diff_c;
   logic [WIDTH-1:0]   res_c;
   logic               carry_c;
   logic               ovf_c;

   assign bus.entrada_ready = (state == OCIOSO);
   assign accept            = bus.entrada_valid && (state == OCIOSO);

   assign sum_c     = {1'b0, bus.A} + {1'b0, bus.B};
   assign diff_c    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
   assign prod_next = acc + (mpl[0] ? mcd : '0);

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      case (bus.ALUOp)
         3'b000: begin
            res_c   = sum_c[WIDTH-1:0];
            carry_c = sum_c[WIDTH];
            ovf_c   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_c[WIDTH-1] != bus.A[WIDTH-1]);
         end
         3'b001: begin
            // carry here means "no borrow"
            res_c   = diff_c[WIDTH-1:0];
            carry_c = diff_c[WIDTH];
            ovf_c   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_c[WIDTH-1] != bus.A[WIDTH-1]);
         end
         3'b010:  res_c = bus.A & bus.B;
         3'b011:  res_c = bus.A | bus.B;
         3'b100:  res_c = bus.A;
         3'b101:  res_c = bus.A ^ bus.B;
         3'b111:  res_c = ~(bus.A | bus.B);
         default: res_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= OCIOSO;
         a_q             <= '0;
         b_q             <= '0;
         mpl             <= '0;
         acc             <= '0;
         mcd             <= '0;
         cnt             <= '0;
         bus.resultado   <= '0;
         bus.zero        <= 1'b0;
         bus.eq          <= 1'b0;
         bus.carry       <= 1'b0;
         bus.overflow    <= 1'b0;
         bus.neg         <= 1'b0;
         bus.saida_valid <= 1'b0;
      end else begin
         case (state)
            OCIOSO: begin
               if (accept) begin
                  a_q <= bus.A;
                  b_q <= bus.B;
                  if (bus.ALUOp == 3'b110) begin
                     acc   <= '0;
                     mcd   <= {{WIDTH{1'b0}}, bus.A};
                     mpl   <= bus.B;
                     cnt   <= CW'(WIDTH);
                     state <= MULT;
                  end else begin
                     bus.resultado   <= res_c;
                     bus.zero        <= (res_c == '0);
                     bus.neg         <= res_c[WIDTH-1];
                     bus.eq          <= (bus.A == bus.B);
                     bus.carry       <= carry_c;
                     bus.overflow    <= ovf_c;
                     bus.saida_valid <= 1'b1;
                     state           <= PRONTO;
                  end
               end
            end
            MULT: begin
               // one multiplier bit per cycle, LSB first; multiplicand walks left
               acc <= prod_next;
               mcd <= mcd << 1;
               mpl <= mpl >> 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bus.resultado   <= prod_next[WIDTH-1:0];
                  bus.zero        <= (prod_next[WIDTH-1:0] == '0);
                  bus.neg         <= prod_next[WIDTH-1];
                  bus.eq          <= (a_q == b_q);
                  bus.carry       <= |prod_next[2*WIDTH-1:WIDTH];
                  bus.overflow    <= 1'b0;
                  bus.saida_valid <= 1'b1;
                  state           <= PRONTO;
               end
            end
            PRONTO: begin
               if (bus.saida_ready) begin
                  bus.saida_valid <= 1'b0;
                  state           <= OCIOSO;
               end
            end
            default: state <= OCIOSO;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multiciclo.sv
// tb/tb_alu_multiciclo.sv - scoreboard bench for alu_multiciclo at WIDTH=8
module tb_alu_multiciclo;
   localparam int W = 8;

   typedef struct packed {
      logic [7:0] res;
      logic       zero;
      logic       eq;
      logic       carry;
      logic       ovf;
      logic       neg;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_multiciclo_if #(.WIDTH(W)) bus ();
   alu_multiciclo #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int   ua, ub, sa, sbv, r, s;
      exp_t e;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sbv = int'($signed(b));
      e = '0;
      r = 0;
      case (op)
         3'd0: begin r = ua + ub; e.carry = (r > 255); s = sa + sbv; e.ovf = (s > 127) || (s < -128); end
         3'd1: begin r = ua - ub; e.carry = (ua >= ub); s = sa - sbv; e.ovf = (s > 127) || (s < -128); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua;
         3'd5: r = ua ^ ub;
         3'd6: begin r = ua * ub; e.carry = (r > 255); end
         default: r = ~(ua | ub);
      endcase
      e.res  = r[7:0];
      e.zero = (e.res == 8'h00);
      e.neg  = e.res[7];
      e.eq   = (a == b);
      return e;
   endfunction

   function automatic exp_t observed();
      return {bus.resultado, bus.zero, bus.eq, bus.carry, bus.overflow, bus.neg};
   endfunction

   // called at a negedge; returns at the negedge after the accepting posedge, valid still high
   task automatic drive_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
      bus.A = a;
      bus.B = b;
      bus.ALUOp = op;
      bus.entrada_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.entrada_ready) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         sb.push_back(model(op, a, b));
         @(negedge clk);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.saida_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.saida_valid) n = -1;
   endtask

   task automatic consume();
      bus.saida_ready = 1'b1;
      @(negedge clk);
      bus.saida_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.saida_valid !== 1'b0) begin errors++; $display("FAIL reset_saida_valid got %b want 0", bus.saida_valid); end
      checks++;
      if (bus.entrada_ready !== 1'b1) begin errors++; $display("FAIL reset_entrada_ready got %b want 1", bus.entrada_ready); end
      checks++;
      if (observed() !== exp_t'(0)) begin errors++; $display("FAIL reset_outputs got %h want 0", observed()); end
   endtask

   task automatic test_add_sub();
      logic [2:0] ops[3]  = '{3'd0, 3'd1, 3'd1};
      logic [7:0] as[3]   = '{8'hFF, 8'h80, 8'h01};
      logic [7:0] bs[3]   = '{8'h01, 8'h01, 8'h02};
      exp_t       want[3] = '{{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
                              {8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
                              {8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      bit   ok;
      int   n;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive_op(ops[i], as[i], bs[i], ok);
         bus.entrada_valid = 1'b0;
         checks++;
         if (!ok) begin errors++; $display("FAIL addsub_accept[%0d] got no accept want accept", i); continue; end
         wait_valid(n);
         e = sb.pop_front();
         checks++;
         if (n !== 0) begin errors++; $display("FAIL addsub_latency[%0d] got %0d want 0", i, n); end
         checks++;
         if (observed() !== want[i]) begin errors++; $display("FAIL addsub_const[%0d] got %h want %h", i, observed(), want[i]); end
         checks++;
         if (observed() !== e) begin errors++; $display("FAIL addsub_model[%0d] got %h want %h", i, observed(), e); end
         consume();
      end
   endtask

   task automatic test_mul();
      logic [7:0] as[2]   = '{8'h10, 8'h0D};
      logic [7:0] bs[2]   = '{8'h10, 8'h0B};
      exp_t       want[2] = '{{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
                              {8'h8F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      bit   ok;
      int   n;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive_op(3'd6, as[i], bs[i], ok);
         bus.entrada_valid = 1'b0;
         bus.A = 8'hFF;
         bus.B = 8'h37;
         checks++;
         if (!ok) begin errors++; $display("FAIL mul_accept[%0d] got no accept want accept", i); continue; end
         wait_valid(n);
         e = sb.pop_front();
         checks++;
         if (n !== W) begin errors++; $display("FAIL mul_latency[%0d] got %0d want %0d", i, n, W); end
         checks++;
         if (observed() !== want[i]) begin errors++; $display("FAIL mul_const[%0d] got %h want %h", i, observed(), want[i]); end
         checks++;
         if (observed() !== e) begin errors++; $display("FAIL mul_model[%0d] got %h want %h", i, observed(), e); end
         consume();
      end
   endtask

   task automatic test_hold();
      bit   ok;
      int   n;
      exp_t e;
      bus.saida_ready = 1'b0;
      drive_op(3'd3, 8'h5A, 8'h5A, ok);
      bus.entrada_valid = 1'b0;
      wait_valid(n);
      e = sb.pop_front();
      checks++;
      if (!ok || n !== 0) begin errors++; $display("FAIL hold_start got ok=%0d lat=%0d want ok=1 lat=0", ok, n); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.saida_valid !== 1'b1 || bus.entrada_ready !== 1'b0 || bus.eq !== 1'b1 || observed() !== e) begin
            errors++;
            $display("FAIL hold[%0d] got v=%b rdy=%b out=%h want v=1 rdy=0 out=%h", i, bus.saida_valid, bus.entrada_ready, observed(), e);
         end
         @(negedge clk);
      end
      consume();
      checks++;
      if (bus.entrada_ready !== 1'b1 || bus.saida_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release got rdy=%b v=%b want rdy=1 v=0", bus.entrada_ready, bus.saida_valid);
      end
   endtask

   task automatic test_reset_mid_mul();
      bit ok;
      bit seen;
      drive_op(3'd6, 8'h0F, 8'h0F, ok);
      bus.entrada_valid = 1'b0;
      if (ok) void'(sb.pop_back());
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (!ok || bus.saida_valid !== 1'b0 || bus.entrada_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_state got ok=%0d v=%b rdy=%b want ok=1 v=0 rdy=1", ok, bus.saida_valid, bus.entrada_ready);
      end
      checks++;
      if (observed() !== exp_t'(0)) begin errors++; $display("FAIL abort_outputs got %h want 0", observed()); end
      seen = 1'b0;
      bus.saida_ready = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.saida_valid) seen = 1'b1;
      end
      bus.saida_ready = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got result want none"); end
   endtask

   task automatic test_back_to_back();
      int got = 0;
      fork
         begin
            bit ok;
            for (int k = 0; k < 10; k++) begin
               drive_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ok);
               if (!ok) begin checks++; errors++; $display("FAIL b2b_accept[%0d] got timeout want accept", k); end
            end
            bus.entrada_valid = 1'b0;
         end
         begin
            exp_t e;
            for (int c = 0; c < 3000 && got < 10; c++) begin
               @(negedge clk);
               bus.saida_ready = 1'($urandom_range(0, 1));
               if (bus.saida_valid && bus.saida_ready) begin
                  checks++;
                  if (sb.size() == 0) begin
                     errors++;
                     $display("FAIL b2b_extra got result %h want none", observed());
                  end else begin
                     e = sb.pop_front();
                     if (observed() !== e) begin errors++; $display("FAIL b2b[%0d] got %h want %h", got, observed(), e); end
                  end
                  got++;
               end
            end
            @(negedge clk);
            bus.saida_ready = 1'b0;
         end
      join
      checks++;
      if (got !== 10 || sb.size() !== 0) begin
         errors++;
         $display("FAIL b2b_count got %0d results, %0d pending want 10, 0", got, sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.A = '0;
      bus.B = '0;
      bus.ALUOp = '0;
      bus.entrada_valid = 1'b0;
      bus.saida_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_add_sub();
      test_mul();
      test_hold();
      test_reset_mid_mul();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
